// File: rtl/uart_rx.sv
// 8N1 serial receiver with optional parity, timed by a clocks-per-bit counter.
// Presents each good byte with a one-cycle strobe; errors pulse for one cycle.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxsd,
  output logic [7:0] rxpd,
  output logic       rxvalid,
  output logic       frame_err,
  output logic       par_err,
  output logic       rxbusy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StStart  = 4'd1,
    StData   = 4'd2,
    StParity = 4'd3,
    StStop   = 4'd4
  } state_e;

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic ParEn  = (PARITY_EN != 0);
  localparam logic OddPar = (PARITY_ODD != 0);

  logic            sync1_q, rx_s, rx_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic [7:0]      rxpd_q, rxpd_d;
  logic            rxvalid_q, rxvalid_d;
  logic            frame_err_q, frame_err_d;
  logic            par_err_q, par_err_d;
  logic            rxbusy_q, rxbusy_d;

  // Synchronizer idles high so a line already low at reset release is not a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_q <= rxsd;
      rx_s    <= sync1_q;
      rx_q    <= rx_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    rxpd_d      = rxpd_q;
    rxvalid_d   = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_q && !rx_s) begin
          cnt_d     = '0;
          par_bad_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          if (!rx_s) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ParEn ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          par_bad_d = (rx_s != ((^shift_q) ^ OddPar));
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            if (par_bad_q) begin
              par_err_d = 1'b1;
            end else begin
              rxpd_d    = shift_q;
              rxvalid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            par_err_d   = par_bad_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    rxbusy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      rxpd_q      <= '0;
      rxvalid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      rxbusy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      rxpd_q      <= rxpd_d;
      rxvalid_q   <= rxvalid_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      rxbusy_q    <= rxbusy_d;
    end
  end

  assign rxpd      = rxpd_q;
  assign rxvalid   = rxvalid_q;
  assign frame_err = frame_err_q;
  assign par_err   = par_err_q;
  assign rxbusy    = rxbusy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance without parity, one with even parity.
module tb_uart_rx;

  localparam int Cpb = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxsd_a, rxsd_b;
  logic [7:0] rxpd_a, rxpd_b;
  logic       rxvalid_a, rxvalid_b, frame_err_a, frame_err_b, par_err_a, par_err_b;
  logic       rxbusy_a, rxbusy_b;
  logic [3:0] state_a, state_b;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .rst(rst), .rxsd(rxsd_a), .rxpd(rxpd_a), .rxvalid(rxvalid_a),
    .frame_err(frame_err_a), .par_err(par_err_a), .rxbusy(rxbusy_a), .state(state_a)
  );

  uart_rx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .rst(rst), .rxsd(rxsd_b), .rxpd(rxpd_b), .rxvalid(rxvalid_b),
    .frame_err(frame_err_b), .par_err(par_err_b), .rxbusy(rxbusy_b), .state(state_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt_a = 0, fe_a = 0, pe_a = 0;
  int vcnt_b = 0, fe_b = 0, pe_b = 0;
  int excl = 0;
  logic [7:0] cap_a[$];

  // Pulse counters: a strobe held two cycles counts twice.
  always @(negedge clk) begin
    if (rxvalid_a) begin
      vcnt_a++;
      cap_a.push_back(rxpd_a);
    end
    if (frame_err_a) fe_a++;
    if (par_err_a) pe_a++;
    if (rxvalid_b) vcnt_b++;
    if (frame_err_b) fe_b++;
    if (par_err_b) pe_b++;
    if (rxvalid_a && (frame_err_a || par_err_a)) excl++;
    if (rxvalid_b && (frame_err_b || par_err_b)) excl++;
  end

  typedef struct {
    bit         use_b;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    int         exp_valid;
    int         exp_fe;
    int         exp_pe;
    logic [7:0] exp_rxpd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_bit(input bit use_b, input logic v);
    if (use_b) rxsd_b = v;
    else rxsd_a = v;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input bit use_b, input logic [7:0] d, input logic pbit,
                            input logic sbit);
    drive_bit(use_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(use_b, d[i]);
    if (use_b) drive_bit(use_b, pbit);
    drive_bit(use_b, sbit);
  endtask

  initial begin
    int v0, f0, p0, c0;

    vecs[0] = '{1'b0, 8'h3A, 1'b0, 1'b1, 1, 0, 0, 8'h3A};
    vecs[1] = '{1'b0, 8'hC3, 1'b0, 1'b1, 1, 0, 0, 8'hC3};
    vecs[2] = '{1'b1, 8'h3A, 1'b0, 1'b1, 1, 0, 0, 8'h3A};
    vecs[3] = '{1'b1, 8'h3A, 1'b1, 1'b1, 0, 0, 1, 8'h3A};
    vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 1, 0, 0, 8'h07};
    vecs[5] = '{1'b1, 8'h07, 1'b0, 1'b0, 0, 1, 1, 8'h07};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
    vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 1, 0, 0, 8'h80};

    rst    = 1'b0;
    rxsd_a = 1'b1;
    rxsd_b = 1'b1;
    @(negedge clk);
    check("reset rxpd", int'(rxpd_a), 0);
    check("reset rxvalid", int'(rxvalid_a), 0);
    check("reset frame_err", int'(frame_err_a), 0);
    check("reset par_err", int'(par_err_a), 0);
    check("reset rxbusy", int'(rxbusy_a), 0);
    check("reset state", int'(state_a), 0);
    check("reset state b", int'(state_b), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      v0 = vecs[k].use_b ? vcnt_b : vcnt_a;
      f0 = vecs[k].use_b ? fe_b : fe_a;
      p0 = vecs[k].use_b ? pe_b : pe_a;
      send_frame(vecs[k].use_b, vecs[k].data, vecs[k].par_bit, vecs[k].stop_bit);
      rxsd_a = 1'b1;
      rxsd_b = 1'b1;
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d rxvalid pulses", k),
            (vecs[k].use_b ? vcnt_b : vcnt_a) - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d frame_err pulses", k),
            (vecs[k].use_b ? fe_b : fe_a) - f0, vecs[k].exp_fe);
      check($sformatf("vec%0d par_err pulses", k),
            (vecs[k].use_b ? pe_b : pe_a) - p0, vecs[k].exp_pe);
      check($sformatf("vec%0d rxpd", k),
            int'(vecs[k].use_b ? rxpd_b : rxpd_a), int'(vecs[k].exp_rxpd));
      check($sformatf("vec%0d state idle", k),
            int'(vecs[k].use_b ? state_b : state_a), 0);
      check($sformatf("vec%0d rxbusy", k), int'(vecs[k].use_b ? rxbusy_b : rxbusy_a), 0);
    end

    // Back-to-back frames with no idle gap.
    v0 = vcnt_a; f0 = fe_a; c0 = cap_a.size();
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
    send_frame(1'b0, 8'h8F, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b rxvalid pulses", vcnt_a - v0, 2);
    check("b2b frame_err", fe_a - f0, 0);
    if (cap_a.size() >= c0 + 2) begin
      check("b2b first byte", int'(cap_a[c0]), 8'hFF);
      check("b2b second byte", int'(cap_a[c0+1]), 8'h8F);
    end else begin
      check("b2b captured bytes", cap_a.size() - c0, 2);
    end

    // Short low glitch: false start.
    v0 = vcnt_a; f0 = fe_a;
    rxsd_a = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch state start", int'(state_a), 1);
    rxsd_a = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch state idle", int'(state_a), 0);
    check("glitch rxvalid", vcnt_a - v0, 0);
    check("glitch frame_err", fe_a - f0, 0);
    check("glitch rxpd kept", int'(rxpd_a), 8'h8F);

    // Bad stop bit, then a long break.
    v0 = vcnt_a; f0 = fe_a;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0);
    check("stop0 frame_err", fe_a - f0, 1);
    check("stop0 rxvalid", vcnt_a - v0, 0);
    check("stop0 rxpd kept", int'(rxpd_a), 8'h8F);
    v0 = vcnt_a; f0 = fe_a;
    repeat (200) @(negedge clk);
    check("break state", int'(state_a), 0);
    check("break rxbusy", int'(rxbusy_a), 0);
    check("break no strobes", (vcnt_a - v0) + (fe_a - f0), 0);
    rxsd_a = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 4.
    v0 = vcnt_a; f0 = fe_a;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    rxsd_a = 1'b1;
    repeat (Cpb / 2) @(negedge clk);
    check("pre-reset busy", int'(rxbusy_a), 1);
    rst = 1'b0;
    #1;
    check("async reset state", int'(state_a), 0);
    check("async reset rxbusy", int'(rxbusy_a), 0);
    check("async reset rxpd", int'(rxpd_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("post-reset no strobes", (vcnt_a - v0) + (fe_a - f0), 0);
    v0 = vcnt_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("A5 rxvalid", vcnt_a - v0, 1);
    check("A5 rxpd", int'(rxpd_a), 8'hA5);
    check("strobe exclusivity", excl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
